// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_pkg
//  Description : Shared types and constants for the ENTER/switch input stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_pkg;

    localparam int c_data_w = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Synchronizes an active-low button, debounces both edges and
//                emits a single-cycle strobe per accepted press.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import input_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_nenter,
    output logic o_pressed,
    output logic o_press_set,
    output logic o_press
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s_n;
    btn_state_t             r_state;
    btn_state_t             w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   r_press;
    logic                   w_press_nxt;

    // Chain resets to the released level so a button held through reset is requalified.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_nenter};
        end
    end

    assign w_s_n = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_s_n) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            PRESS_WAIT: begin
                if (w_s_n) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            HELD: begin
                if (w_s_n) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            RELEASE_WAIT: begin
                if (!w_s_n) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_pressed   = (r_state == HELD) || (r_state == RELEASE_WAIT);
    assign o_press_set = w_press_nxt;
    assign o_press     = r_press;

endmodule
`default_nettype wire

// File: rtl/enter_input_stage.sv
`default_nettype none
// ============================================================================
//  Module      : enter_input_stage
//  Description : Conditions the ENTER button and switch word, capturing the
//                word on each press behind a valid/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module enter_input_stage
    import input_pkg::*;
#(
    parameter int DATA_W          = c_data_w,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              nenter,
    input  logic [DATA_W-1:0] inputdata,
    input  logic              data_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              enter_pulse,
    output logic              overrun
);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_dsync;
    logic [DATA_W-1:0]                  w_sdata;
    logic                               w_pressed;
    logic                               w_press_set;
    logic                               w_capture;
    logic [DATA_W-1:0]                  r_data;
    logic                               r_valid;
    logic                               r_overrun;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_dsync <= '0;
        end else begin
            r_dsync <= {r_dsync[SYNC_STAGES-2:0], inputdata};
        end
    end

    assign w_sdata = r_dsync[SYNC_STAGES-1];

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_debouncer (
        .clk         (clk),
        .nreset      (nreset),
        .i_nenter    (nenter),
        .o_pressed   (w_pressed),
        .o_press_set (w_press_set),
        .o_press     (enter_pulse)
    );

    // A press can only qualify from the released side of the debouncer.
    assign w_capture = w_press_set & ~w_pressed;

    // An ack in the capture cycle frees the slot, so the new word replaces the old one.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_capture) begin
            if (!r_valid || data_ack) begin
                r_data  <= w_sdata;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && data_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_enter_input_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enter_input_stage
//  Description : Directed bench for enter_input_stage (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enter_input_stage;

    localparam int DATA_W          = 8;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    // Cycles from the first edge sampling a stable low to the edge registering the strobe.
    localparam int c_lat           = SYNC_STAGES + DEBOUNCE_CYCLES - 1;

    logic              clk = 1'b0;
    logic              nreset;
    logic              nenter;
    logic [DATA_W-1:0] inputdata;
    logic              data_ack;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              enter_pulse;
    logic              overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    enter_input_stage #(
        .DATA_W          (DATA_W),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .nenter      (nenter),
        .inputdata   (inputdata),
        .data_ack    (data_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .enter_pulse (enter_pulse),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic v,
                              input logic p, input logic o);
        check({tag, " data_out"},    32'(data_out),    32'(d));
        check({tag, " data_valid"},  32'(data_valid),  32'(v));
        check({tag, " enter_pulse"}, 32'(enter_pulse), 32'(p));
        check({tag, " overrun"},     32'(overrun),     32'(o));
    endtask

    // Called right after nenter goes low (or reset releases) at a falling edge.
    task automatic timed_press(input string tag, input bit ack_last);
        int early;
        early = 0;
        for (int i = 0; i < c_lat; i++) begin
            @(negedge clk);
            early += int'(enter_pulse);
        end
        check({tag, " early strobe"}, 32'(early), 32'd0);
        if (ack_last) data_ack = 1'b1;
        @(negedge clk);
        check({tag, " strobe"}, 32'(enter_pulse), 32'd1);
        data_ack = 1'b0;
        @(negedge clk);
        check({tag, " single"}, 32'(enter_pulse), 32'd0);
    endtask

    task automatic release_btn(input string tag);
        int cnt;
        cnt    = 0;
        nenter = 1'b1;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(enter_pulse);
        end
        check({tag, " release strobe"}, 32'(cnt), 32'd0);
    endtask

    task automatic ack_once();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        int cnt;
        nreset    = 1'b0;
        nenter    = 1'b0;
        inputdata = 8'hFF;
        data_ack  = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        nenter   = 1'b1;
        data_ack = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(enter_pulse);
        end
        check("post-reset strobes", 32'(cnt), 32'd0);
        check_outs("post-reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Clean press
        inputdata = 8'hA5;
        nenter    = 1'b0;
        timed_press("clean", 1'b0);
        check_outs("clean", 8'hA5, 1'b1, 1'b0, 1'b0);
        release_btn("clean");
        check("clean held valid", 32'(data_valid), 32'd1);
        ack_once();
        check_outs("clean ack", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Glitch one cycle short of qualifying
        cnt    = 0;
        nenter = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cnt += int'(enter_pulse);
        end
        nenter = 1'b1;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(enter_pulse);
        end
        check("glitch strobes", 32'(cnt), 32'd0);
        check("glitch valid", 32'(data_valid), 32'd0);

        // Bounce: timing restarts from the last falling edge
        inputdata = 8'h5A;
        nenter    = 1'b0;
        repeat (2) @(negedge clk);
        nenter = 1'b1;
        @(negedge clk);
        nenter = 1'b0;
        timed_press("bounce", 1'b0);
        check_outs("bounce", 8'h5A, 1'b1, 1'b0, 1'b0);
        release_btn("bounce");
        ack_once();
        check("bounce ack valid", 32'(data_valid), 32'd0);

        // Overrun
        inputdata = 8'hA5;
        nenter    = 1'b0;
        timed_press("ovr first", 1'b0);
        check_outs("ovr first", 8'hA5, 1'b1, 1'b0, 1'b0);
        release_btn("ovr first");
        inputdata = 8'h3C;
        nenter    = 1'b0;
        timed_press("ovr second", 1'b0);
        check_outs("ovr second", 8'hA5, 1'b1, 1'b0, 1'b1);
        release_btn("ovr second");
        ack_once();
        check_outs("ovr ack", 8'hA5, 1'b0, 1'b0, 1'b1);

        // Same-cycle ack and press
        do_reset();
        @(negedge clk);
        check("reset clears overrun", 32'(overrun), 32'd0);
        inputdata = 8'hA5;
        nenter    = 1'b0;
        timed_press("pend", 1'b0);
        release_btn("pend");
        inputdata = 8'h3C;
        nenter    = 1'b0;
        timed_press("ackpress", 1'b1);
        check_outs("ackpress", 8'h3C, 1'b1, 1'b0, 1'b0);
        release_btn("ackpress");

        // Reset during PRESS_WAIT with cnt=2, button held through reset
        nenter = 1'b0;
        repeat (4) @(negedge clk);
        nreset = 1'b0;
        #1;
        check_outs("mid reset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        timed_press("requal", 1'b0);
        check_outs("requal", 8'h3C, 1'b1, 1'b0, 1'b0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(enter_pulse);
        end
        check("held no repeat", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
